uart_led_cmd_ctrl: RTL
======================

Name: uart_led_cmd_ctrl

Overview:
- Byte-stream command decoder and N-channel PWM LED driver; next generation of the badge "shooting flags" cat-status logic.
- Consumes bytes from the UART RX core and maintains a per-channel hit mask, as the old single-byte 'A'..'H' / '`' scheme did.
- Adds a multi-byte brightness command, per-channel duty, timeout and error reporting.
- Output feeds the board LED mux in UART mode.

Parameters:
- NUM_CH, 8, number of LED channels (1..26).
- PWM_BITS, 4, PWM counter and duty width (1..8).
- DEFAULT_DUTY, 2**PWM_BITS-1, reset duty of every channel.
- CMD_TIMEOUT, 1_033_400, cycles allowed between bytes of a multi-byte command (10 ms at 103.34 MHz).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe, rx_data valid; back-to-back strobes allowed.
- led_base  in  NUM_CH  pattern from challenge logic (e.g. shooting-flags cats).
- led_out  out  NUM_CH  registered, PWM-gated LED drive.
- hit_mask  out  NUM_CH  current hit mask (1 = channel hit).
- cmd_err  out  1  one-cycle pulse on a malformed or timed-out command.
- busy  out  1  high while a multi-byte command is in progress.

Behaviour:
- Reset (async, active-high):
  - hit_mask=0, all duty=DEFAULT_DUTY, state=IDLE.
  - led_out=0, cmd_err=0, busy=0, PWM counter=0, timeout counter=0.
- Byte handling: one byte accepted per rx_valid cycle. Register updates are visible on hit_mask the next cycle. led_out lags hit_mask by one further cycle (registered output stage).
- FSM IDLE:
  - 0x41+i with i<NUM_CH: set hit[i].
  - 0x60: clear all hits.
  - 0x23 ('#'): go to GET_CH.
  - Any other byte: ignored, no error. 0x41+NUM_CH and above is ignored; the range check is strict.
- FSM GET_CH:
  - Byte 0x30+i with i<NUM_CH: latch ch=i, go to GET_DUTY.
  - Any other byte: cmd_err pulse, go to IDLE.
- FSM GET_DUTY:
  - Any byte: duty[ch] <= rx_data[PWM_BITS-1:0], go to IDLE. Upper bits are discarded.
- Operand priority: in GET_CH/GET_DUTY, bytes are always operands. 0x60 and 'A'.. are not interpreted as commands.
- busy = (state != IDLE).
- Timeout:
  - The counter clears on every accepted byte and counts while busy.
  - When it reaches CMD_TIMEOUT-1 with no byte: cmd_err pulse, go to IDLE, partial command discarded, duty unchanged.
  - If a byte arrives on the same cycle as expiry, the byte wins and there is no error.
- PWM:
  - Free-running PWM_BITS counter, wraps from all-ones to 0.
  - on[i] = (cnt < duty[i]) OR (duty[i] == all-ones). Duty 0 means always off; all-ones means always on.
- Output: led_out[i] <= (led_base[i] | hit[i]) & on[i].
- Simultaneous events: the hit-set and clear paths are exclusive per byte, so no conflict arises. A reset mid-command returns to IDLE immediately and the in-flight duty write is lost.
- Width rules: channel index width is $clog2(NUM_CH) (minimum 1). Compare ch offsets as 8-bit unsigned subtraction with a bound check before indexing.

Decomposition:
- Package uart_led_cmd_pkg:
  - Byte constants CMD_HIT_BASE=8'h41, CMD_CLEAR=8'h60, CMD_DUTY=8'h23, CMD_CH_BASE=8'h30.
  - FSM state encoding IDLE/GET_CH/GET_DUTY.
- Sub-module pwm_channel_bank (NUM_CH, PWM_BITS): holds the counter and per-channel compare, takes the duty vector, outputs the on vector.
- Decoder, FSM, timeout and output register live in the parent.

Test Plan:
- Reset, then bytes 0x41, 0x43 -> hit_mask=8'b0000_0101 one cycle after the second strobe. led_out bits 0,2 follow one cycle later at 100% duty.
- Byte 0x49 with NUM_CH=8 -> hit_mask unchanged, no cmd_err. Then 0x60 -> hit_mask=0.
- '#', '3', 8'h04 with PWM_BITS=4 and hit[3] set -> led_out[3] high exactly 4 of every 16 cycles. Duty 0 -> never high; 0x0F -> always high.
- '#', then 'Z' -> single cmd_err pulse, busy drops next cycle, all duties unchanged.
- '#', '1', then idle for CMD_TIMEOUT cycles -> cmd_err pulse at expiry, state IDLE. A following 0x42 sets hit[1] normally.
- Assert reset mid-command after '#','2' -> busy=0, led_out=0, hit_mask=0, duty restored to DEFAULT_DUTY asynchronously.

Source files
------------

// File: rtl/uart_led_cmd_pkg.sv
// -----------------------------------------------------------------------------
// uart_led_cmd_pkg
// Shared definitions for the UART LED command controller:
//   - command byte constants of the byte-stream protocol
//   - command decoder FSM state encoding
// -----------------------------------------------------------------------------
package uart_led_cmd_pkg;

   // Single-byte commands accepted in IDLE
   localparam logic [7:0] CMD_HIT_BASE = 8'h41;  // 'A' + i sets hit[i]
   localparam logic [7:0] CMD_CLEAR    = 8'h60;  // '`' clears all hits
   localparam logic [7:0] CMD_DUTY     = 8'h23;  // '#' starts a brightness command

   // Channel operand of the brightness command: '0' + i selects channel i
   localparam logic [7:0] CMD_CH_BASE  = 8'h30;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      GET_CH   = 2'd1,
      GET_DUTY = 2'd2
   } state_e;

endpackage : uart_led_cmd_pkg

// File: rtl/uart_led_cmd_ctrl_pwm.sv
// -----------------------------------------------------------------------------
// pwm_channel_bank
// Free-running PWM counter shared by all channels plus one duty compare per
// channel. A duty of 0 keeps the channel off; all-ones keeps it on for the
// whole period (the plain compare alone would leave one dark cycle).
//
// Ports:
//   clk    in   system clock
//   reset  in   asynchronous active-high reset (counter -> 0)
//   duty   in   NUM_CH x PWM_BITS duty values
//   on     out  NUM_CH per-channel PWM enable (combinational from counter)
// -----------------------------------------------------------------------------
module pwm_channel_bank
   import uart_led_cmd_pkg::*;
#(
   parameter int NUM_CH   = 8,
   parameter int PWM_BITS = 4
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [NUM_CH-1:0][PWM_BITS-1:0]    duty,
   output logic [NUM_CH-1:0]                  on
);

   logic [PWM_BITS-1:0] cnt_q;
   logic [PWM_BITS-1:0] cnt_d;

   // Wraps naturally from all-ones back to zero.
   always_comb begin
      cnt_d = cnt_q + PWM_BITS'(1);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   always_comb begin
      on = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         on[i] = (cnt_q < duty[i]) || (duty[i] == '1);
      end
   end

endmodule : pwm_channel_bank

// File: rtl/uart_led_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// uart_led_cmd_ctrl
// Byte-stream command decoder and N-channel PWM LED driver.
//   IDLE     : 'A'+i sets hit[i], '`' clears all hits, '#' starts a
//              brightness command, everything else is ignored.
//   GET_CH   : '0'+i selects channel i, anything else is a command error.
//   GET_DUTY : low PWM_BITS of the byte become duty[ch].
// A multi-byte command that stalls for CMD_TIMEOUT cycles is abandoned with
// a cmd_err pulse. led_out is the PWM-gated OR of led_base and hit_mask,
// registered once more after hit_mask.
//
// Ports:
//   clk       in   system clock
//   reset     in   asynchronous active-high reset
//   rx_data   in   [7:0] received byte
//   rx_valid  in   one-cycle strobe qualifying rx_data
//   led_base  in   [NUM_CH-1:0] pattern from challenge logic
//   led_out   out  [NUM_CH-1:0] registered, PWM-gated LED drive
//   hit_mask  out  [NUM_CH-1:0] current hit mask
//   cmd_err   out  one-cycle pulse on malformed or timed-out command
//   busy      out  high while a multi-byte command is in progress
// -----------------------------------------------------------------------------
module uart_led_cmd_ctrl
   import uart_led_cmd_pkg::*;
#(
   parameter int NUM_CH       = 8,
   parameter int PWM_BITS     = 4,
   parameter int DEFAULT_DUTY = 2**PWM_BITS - 1,
   parameter int CMD_TIMEOUT  = 1_033_400
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   input  logic [NUM_CH-1:0] led_base,
   output logic [NUM_CH-1:0] led_out,
   output logic [NUM_CH-1:0] hit_mask,
   output logic              cmd_err,
   output logic              busy
);

   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int TMO_W = (CMD_TIMEOUT > 1) ? $clog2(CMD_TIMEOUT) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(CMD_TIMEOUT - 1);

   state_e                            state_q,   state_d;
   logic [CH_W-1:0]                   ch_q,      ch_d;
   logic [NUM_CH-1:0]                 hit_q,     hit_d;
   logic [NUM_CH-1:0][PWM_BITS-1:0]   duty_q,    duty_d;
   logic [TMO_W-1:0]                  tmo_q,     tmo_d;
   logic [NUM_CH-1:0]                 led_out_q, led_out_d;
   logic                              cmd_err_q, cmd_err_d;

   logic [7:0]        hit_off;
   logic [7:0]        ch_off;
   logic              hit_ok;
   logic              ch_ok;
   logic [CH_W-1:0]   hit_idx;
   logic [CH_W-1:0]   ch_idx;
   logic [NUM_CH-1:0] pwm_on;

   // Offsets wrap as 8-bit unsigned, so bytes below the base become large
   // values and fail the bound check; only in-range offsets are used as
   // indices.
   always_comb begin
      hit_off = rx_data - CMD_HIT_BASE;
      ch_off  = rx_data - CMD_CH_BASE;
      hit_ok  = (hit_off < 8'(NUM_CH));
      ch_ok   = (ch_off  < 8'(NUM_CH));
      hit_idx = CH_W'(hit_off);
      ch_idx  = CH_W'(ch_off);
   end

   // Decoder, FSM next state and timeout counter.
   // NOTE: every variable gets its hold/idle value before any branch, so no
   // path can leave one unassigned and infer a latch.
   always_comb begin
      state_d   = state_q;
      ch_d      = ch_q;
      hit_d     = hit_q;
      duty_d    = duty_q;
      tmo_d     = tmo_q;
      cmd_err_d = 1'b0;

      if (rx_valid) begin
         // A byte always restarts the inter-byte window and beats expiry.
         tmo_d = '0;
         unique case (state_q)
            IDLE: begin
               if (hit_ok) begin
                  hit_d[hit_idx] = 1'b1;
               end else if (rx_data == CMD_CLEAR) begin
                  hit_d = '0;
               end else if (rx_data == CMD_DUTY) begin
                  state_d = GET_CH;
               end
            end
            GET_CH: begin
               if (ch_ok) begin
                  ch_d    = ch_idx;
                  state_d = GET_DUTY;
               end else begin
                  cmd_err_d = 1'b1;
                  state_d   = IDLE;
               end
            end
            GET_DUTY: begin
               duty_d[ch_q] = PWM_BITS'(rx_data);
               state_d      = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end else if (state_q != IDLE) begin
         if (tmo_q == TMO_LAST) begin
            cmd_err_d = 1'b1;
            state_d   = IDLE;
            tmo_d     = '0;
         end else begin
            tmo_d = tmo_q + TMO_W'(1);
         end
      end else begin
         tmo_d = '0;
      end
   end

   pwm_channel_bank #(
      .NUM_CH   (NUM_CH),
      .PWM_BITS (PWM_BITS)
   ) u_pwm (
      .clk   (clk),
      .reset (reset),
      .duty  (duty_q),
      .on    (pwm_on)
   );

   always_comb begin
      led_out_d = (led_base | hit_q) & pwm_on;
   end

   // NOTE: the duty array is a handful of flops that must come up at a known
   // brightness, so it is reset like any other register rather than treated
   // as an uninitialised memory.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         ch_q      <= '0;
         hit_q     <= '0;
         duty_q    <= {NUM_CH{PWM_BITS'(DEFAULT_DUTY)}};
         tmo_q     <= '0;
         led_out_q <= '0;
         cmd_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ch_q      <= ch_d;
         hit_q     <= hit_d;
         duty_q    <= duty_d;
         tmo_q     <= tmo_d;
         led_out_q <= led_out_d;
         cmd_err_q <= cmd_err_d;
      end
   end

   assign led_out  = led_out_q;
   assign hit_mask = hit_q;
   assign cmd_err  = cmd_err_q;
   assign busy     = (state_q != IDLE);

endmodule : uart_led_cmd_ctrl
